// File: rtl/parity_frame_serializer.sv
// Serialises a WIDTH-bit word LSB first, then appends an even/odd parity bit chosen per frame.
// Also keeps a wrapping count of the frames it has completed.
module parity_frame_serializer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] D,
    input  logic             ODD,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic             SOUT,
    output logic             SVALID,
    output logic             PBIT,
    output logic             DONE,
    output logic             BUSY,
    output logic [CNT_W-1:0] FCOUNT
);

    localparam int unsigned BitCntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BitCntW-1:0] LastBit = BitCntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [BitCntW-1:0] bit_q, bit_d;
    logic               par_q, par_d;
    logic               sout_q, sout_d;
    logic               svalid_q, svalid_d;
    logic               pbit_q, pbit_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   fcount_q, fcount_d;
    logic               accept;

    // Ready is decoded from state only, so the parity cycle can take the next word.
    assign IN_READY = (state_q != StData);
    assign accept   = IN_VALID & IN_READY;

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bit_d    = bit_q;
        par_d    = par_q;
        sout_d   = 1'b0;
        svalid_d = 1'b0;
        pbit_d   = 1'b0;
        done_d   = 1'b0;
        busy_d   = 1'b0;
        fcount_d = fcount_q;

        if (state_q == StParity) begin
            fcount_d = fcount_q + 1'b1;
        end

        unique case (state_q)
            StIdle, StParity: begin
                if (accept) begin
                    state_d  = StData;
                    // Bit 0 goes straight to SOUT; the register keeps the rest.
                    shift_d  = {1'b0, D[WIDTH-1:1]};
                    bit_d    = '0;
                    par_d    = (^D) ^ ODD;
                    sout_d   = D[0];
                    svalid_d = 1'b1;
                    busy_d   = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            StData: begin
                svalid_d = 1'b1;
                busy_d   = 1'b1;
                if (bit_q == LastBit) begin
                    state_d = StParity;
                    sout_d  = par_q;
                    pbit_d  = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    bit_d   = bit_q + 1'b1;
                    sout_d  = shift_q[0];
                    shift_d = shift_q >> 1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= StIdle;
            shift_q  <= '0;
            bit_q    <= '0;
            par_q    <= 1'b0;
            sout_q   <= 1'b0;
            svalid_q <= 1'b0;
            pbit_q   <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            fcount_q <= '0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bit_q    <= bit_d;
            par_q    <= par_d;
            sout_q   <= sout_d;
            svalid_q <= svalid_d;
            pbit_q   <= pbit_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            fcount_q <= fcount_d;
        end
    end

    assign SOUT   = sout_q;
    assign SVALID = svalid_q;
    assign PBIT   = pbit_q;
    assign DONE   = done_q;
    assign BUSY   = busy_q;
    assign FCOUNT = fcount_q;

endmodule

// File: tb/tb_parity_frame_serializer.sv
// Scoreboard bench: each accepted word queues its expected serial frame, and every cycle's
// outputs are compared against the queue head.
module tb_parity_frame_serializer;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 2;

    typedef struct packed {
        logic sout;
        logic pbit;
        logic done;
    } exp_t;

    logic             CLK = 1'b0;
    logic             RST;
    logic [WIDTH-1:0] D;
    logic             ODD;
    logic             IN_VALID;
    logic             IN_READY;
    logic             SOUT;
    logic             SVALID;
    logic             PBIT;
    logic             DONE;
    logic             BUSY;
    logic [CNT_W-1:0] FCOUNT;

    exp_t             q[$];
    logic             par_log[$];
    logic [CNT_W-1:0] exp_fcount;
    logic             last_acc;
    logic             last_par;
    int               run_len;
    int               max_run;
    int               n_checks;
    int               n_errors;
    int               exp6[5] = '{1, 2, 3, 0, 1};

    parity_frame_serializer #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .D       (D),
        .ODD     (ODD),
        .IN_VALID(IN_VALID),
        .IN_READY(IN_READY),
        .SOUT    (SOUT),
        .SVALID  (SVALID),
        .PBIT    (PBIT),
        .DONE    (DONE),
        .BUSY    (BUSY),
        .FCOUNT  (FCOUNT)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: decide acceptance from the model, update the model at the edge,
    // then compare the settled outputs at the falling edge.
    task automatic step();
        logic exp_ready;
        logic acc;
        exp_t h;
        exp_ready = (q.size() == 0) || q[0].pbit;
        acc = IN_VALID && exp_ready && !RST;
        last_acc = acc;
        @(posedge CLK);
        if (RST) begin
            q.delete();
            exp_fcount = '0;
        end else begin
            if (q.size() > 0) begin
                h = q.pop_front();
                if (h.pbit) exp_fcount = exp_fcount + 1'b1;
            end
            if (acc) begin
                for (int i = 0; i < WIDTH; i++) q.push_back('{sout: D[i], pbit: 1'b0, done: 1'b0});
                q.push_back('{sout: (^D) ^ ODD, pbit: 1'b1, done: 1'b1});
            end
        end
        @(negedge CLK);
        if (q.size() > 0) begin
            h = q[0];
            check_eq("sout", 32'(SOUT), 32'(h.sout));
            check_eq("svalid", 32'(SVALID), 32'd1);
            check_eq("pbit", 32'(PBIT), 32'(h.pbit));
            check_eq("done", 32'(DONE), 32'(h.done));
            check_eq("busy", 32'(BUSY), 32'd1);
            check_eq("in_ready", 32'(IN_READY), 32'(h.pbit));
        end else begin
            check_eq("idle_sout", 32'(SOUT), 32'd0);
            check_eq("idle_svalid", 32'(SVALID), 32'd0);
            check_eq("idle_pbit", 32'(PBIT), 32'd0);
            check_eq("idle_done", 32'(DONE), 32'd0);
            check_eq("idle_busy", 32'(BUSY), 32'd0);
            check_eq("idle_in_ready", 32'(IN_READY), 32'd1);
        end
        check_eq("fcount", 32'(FCOUNT), 32'(exp_fcount));
        if (SVALID === 1'b1) run_len++;
        else run_len = 0;
        if (run_len > max_run) max_run = run_len;
        if (PBIT === 1'b1) begin
            last_par = SOUT;
            par_log.push_back(SOUT);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < 64) begin
            step();
            n++;
        end
        step();
    endtask

    task automatic send(input logic [WIDTH-1:0] d, input logic odd);
        last_par = 1'bx;
        D = d;
        ODD = odd;
        IN_VALID = 1'b1;
        step();
        IN_VALID = 1'b0;
        D = WIDTH'($urandom);
        ODD = 1'($urandom);
        drain();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        exp_fcount = '0;
        run_len = 0;
        max_run = 0;
        last_par = 1'bx;
        RST = 1'b1;
        D = '0;
        ODD = 1'b0;
        IN_VALID = 1'b0;
        step();
        step();
        RST = 1'b0;
        step();
        check_eq("reset_fcount", 32'(FCOUNT), 32'd0);

        // Single frames with known parity.
        send(8'hA5, 1'b0);
        check_eq("par_a5_even", 32'(last_par), 32'd0);
        check_eq("fcount_after_first", 32'(FCOUNT), 32'd1);
        send(8'hA5, 1'b1);
        check_eq("par_a5_odd", 32'(last_par), 32'd1);
        send(8'h07, 1'b0);
        check_eq("par_07_even", 32'(last_par), 32'd1);
        send(8'h00, 1'b0);
        check_eq("par_00_even", 32'(last_par), 32'd0);

        // Back-to-back: second word taken in the first frame's parity cycle.
        par_log.delete();
        max_run = 0;
        D = 8'h01;
        ODD = 1'b0;
        IN_VALID = 1'b1;
        step();
        D = 8'hFF;
        begin
            int n;
            n = 0;
            last_acc = 1'b0;
            while (!last_acc && n < 20) begin
                step();
                n++;
            end
        end
        IN_VALID = 1'b0;
        drain();
        check_eq("b2b_run", 32'(max_run), 32'd18);
        check_eq("b2b_npar", 32'(par_log.size()), 32'd2);
        if (par_log.size() == 2) begin
            check_eq("b2b_par0", 32'(par_log[0]), 32'd1);
            check_eq("b2b_par1", 32'(par_log[1]), 32'd0);
        end
        check_eq("b2b_fcount", 32'(FCOUNT), 32'd2);

        // Reset while data bit 3 is on the line.
        D = 8'h3C;
        ODD = 1'b0;
        IN_VALID = 1'b1;
        step();
        IN_VALID = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check_eq("pre_abort_busy", 32'(BUSY), 32'd1);
        RST = 1'b1;
        step();
        RST = 1'b0;
        check_eq("abort_fcount", 32'(FCOUNT), 32'd0);
        step();
        send(8'h96, 1'b1);
        check_eq("par_96_odd", 32'(last_par), 32'd1);

        // Reset beats a simultaneous accept, then counter wrap with CNT_W=2.
        RST = 1'b1;
        IN_VALID = 1'b1;
        D = 8'h55;
        step();
        RST = 1'b0;
        IN_VALID = 1'b0;
        step();
        for (int f = 0; f < 5; f++) begin
            D = WIDTH'($urandom);
            ODD = 1'($urandom);
            IN_VALID = 1'b1;
            step();
            for (int j = 0; j < 4; j++) begin
                IN_VALID = ~IN_VALID;
                D = WIDTH'($urandom);
                ODD = 1'($urandom);
                step();
            end
            IN_VALID = 1'b0;
            drain();
            check_eq("wrap_fcount", 32'(FCOUNT), 32'(exp6[f]));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
